// File: rtl/training_data_feeder.sv
// Streams stored training vectors and the query vector, chunk by chunk, to the distance calculator.
// Optional handshake checking is compiled in with `define FEEDER_PROTOCOL_CHECK_EN.
module training_data_feeder #(
    parameter int M            = 4,
    parameter int N            = 4,
    parameter int W            = 16,
    parameter int MAX_ELEMENTS = 4,
    parameter int TYPE_W       = 4,
    parameter int NUM_SAMPLES  = 8,
    localparam int L           = M * N,
    localparam int IDX_W       = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
    localparam int ELEM_W      = (L > 1) ? $clog2(L) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [IDX_W-1:0]    wr_sample,
    input  logic [ELEM_W-1:0]   wr_elem,
    input  logic [W-1:0]        wr_data,
    input  logic                wr_type_en,
    input  logic [TYPE_W-1:0]   wr_type,
    input  logic                start,
    input  logic [IDX_W:0]      sample_count,
    input  logic                data_request,
    input  logic                done,
    output logic [W*M*N-1:0]    training_data,
    output logic [TYPE_W-1:0]   training_data_type,
    output logic [W*M*N-1:0]    input_data,
    output logic                ready,
    output logic                busy,
    output logic [IDX_W-1:0]    sample_index,
    output logic                pass_done,
    output logic                protocol_error
);

    localparam int C       = (L + MAX_ELEMENTS - 1) / MAX_ELEMENTS;
    localparam int CHUNK_W = (C > 1) ? $clog2(C) : 1;
    localparam int CNT_W   = IDX_W + 1;

    typedef enum logic [2:0] {IDLE, LOAD, PRESENT, WAIT, FINISH} state_t;

    state_t               state, state_nxt;
    logic [W-1:0]         train_mem [NUM_SAMPLES][L];
    logic [W-1:0]         query_mem [L];
    logic [TYPE_W-1:0]    label_mem [NUM_SAMPLES];
    logic [CNT_W-1:0]     count_q;
    logic [CHUNK_W-1:0]   chunk_idx;
    logic                 last_chunk;
    logic                 more_samples;
    logic [W*L-1:0]       chunk_train;
    logic [W*L-1:0]       chunk_query;

    assign last_chunk   = (int'(chunk_idx) == C - 1);
    assign more_samples = ({1'b0, sample_index} + CNT_W'(1)) < count_q;

    assign ready = (state == PRESENT);
    assign busy  = (state != IDLE);
    assign pass_done = (state == FINISH);

    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en && int'(wr_elem) < L) begin
            if (wr_sel) begin
                query_mem[wr_elem] <= wr_data;
            end else if (int'(wr_sample) < NUM_SAMPLES) begin
                train_mem[wr_sample][wr_elem] <= wr_data;
                if (wr_type_en) label_mem[wr_sample] <= wr_type;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (sample_count == '0) ? FINISH : LOAD;
            LOAD:    state_nxt = PRESENT;
            PRESENT: state_nxt = WAIT;
            WAIT: begin
                if (done)                             state_nxt = more_samples ? LOAD : FINISH;
                else if (data_request && !last_chunk) state_nxt = LOAD;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counts beyond capacity are clamped so the sample index never leaves the memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            sample_index <= '0;
            chunk_idx    <= '0;
        end else if (state == IDLE && start) begin
            count_q      <= (int'(sample_count) > NUM_SAMPLES) ? CNT_W'(NUM_SAMPLES) : sample_count;
            sample_index <= '0;
            chunk_idx    <= '0;
        end else if (state == WAIT) begin
            if (done) begin
                if (more_samples) begin
                    sample_index <= sample_index + IDX_W'(1);
                    chunk_idx    <= '0;
                end
            end else if (data_request && !last_chunk) begin
                chunk_idx <= chunk_idx + CHUNK_W'(1);
            end
        end
    end

    always_comb begin
        chunk_train = '0;
        chunk_query = '0;
        for (int k = 0; k < MAX_ELEMENTS; k++) begin
            if (int'(chunk_idx) * MAX_ELEMENTS + k < L) begin
                chunk_train[k*W +: W] = train_mem[sample_index][ELEM_W'(int'(chunk_idx) * MAX_ELEMENTS + k)];
                chunk_query[k*W +: W] = query_mem[ELEM_W'(int'(chunk_idx) * MAX_ELEMENTS + k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            training_data      <= '0;
            input_data         <= '0;
            training_data_type <= '0;
        end else if (state == LOAD) begin
            training_data      <= chunk_train;
            input_data         <= chunk_query;
            training_data_type <= label_mem[sample_index];
        end
    end

`ifdef FEEDER_PROTOCOL_CHECK_EN
    logic violation;
    logic protocol_error_q;

    always_comb begin
        violation = 1'b0;
        if (state != WAIT) violation = data_request || done;
        else violation = (data_request && last_chunk) || (done && data_request) || (done && !last_chunk);
    end

    always_ff @(posedge clk) begin
        if (rst)            protocol_error_q <= 1'b0;
        else if (violation) protocol_error_q <= 1'b1;
    end

    assign protocol_error = protocol_error_q;
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_training_data_feeder.sv
// Bench for training_data_feeder: default geometry with randomized contents, plus a 2x5 instance for partial chunks.
module tb_training_data_feeder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: default parameters (L=16, C=4)
    logic         a_wr_en, a_wr_sel, a_wr_type_en, a_start, a_dr, a_done;
    logic [2:0]   a_wr_sample;
    logic [3:0]   a_wr_elem, a_wr_type, a_count;
    logic [15:0]  a_wr_data;
    logic [255:0] a_td, a_qd;
    logic [3:0]   a_type;
    logic         a_ready, a_busy, a_pdone, a_perr;
    logic [2:0]   a_sidx;

    training_data_feeder dut_a (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_sel(a_wr_sel), .wr_sample(a_wr_sample),
        .wr_elem(a_wr_elem), .wr_data(a_wr_data), .wr_type_en(a_wr_type_en), .wr_type(a_wr_type),
        .start(a_start), .sample_count(a_count), .data_request(a_dr), .done(a_done),
        .training_data(a_td), .training_data_type(a_type), .input_data(a_qd), .ready(a_ready),
        .busy(a_busy), .sample_index(a_sidx), .pass_done(a_pdone), .protocol_error(a_perr)
    );

    // Instance B: M=2, N=5 gives L=10 and C=3 with a partial last chunk
    logic         b_wr_en, b_wr_sel, b_wr_type_en, b_start, b_dr, b_done;
    logic [2:0]   b_wr_sample;
    logic [3:0]   b_wr_elem, b_wr_type, b_count;
    logic [15:0]  b_wr_data;
    logic [159:0] b_td, b_qd;
    logic [3:0]   b_type;
    logic         b_ready, b_busy, b_pdone, b_perr;
    logic [2:0]   b_sidx;

    training_data_feeder #(.M(2), .N(5)) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_sample(b_wr_sample),
        .wr_elem(b_wr_elem), .wr_data(b_wr_data), .wr_type_en(b_wr_type_en), .wr_type(b_wr_type),
        .start(b_start), .sample_count(b_count), .data_request(b_dr), .done(b_done),
        .training_data(b_td), .training_data_type(b_type), .input_data(b_qd), .ready(b_ready),
        .busy(b_busy), .sample_index(b_sidx), .pass_done(b_pdone), .protocol_error(b_perr)
    );

    int passed = 0;
    int total  = 0;

    logic [15:0] m_train [8][16];
    logic [15:0] m_query [16];
    logic [3:0]  m_label [8];
    logic        perr_exp;
    bit          aborted;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] exp_chunk(input bit q, input int s, input int c);
        logic [255:0] r = '0;
        for (int k = 0; k < 4; k++) begin
            int e = c * 4 + k;
            if (e < 16) r[k*16 +: 16] = q ? m_query[e] : m_train[s][e];
        end
        return r;
    endfunction

    function automatic logic [255:0] b_chunk(input bit q, input int c);
        logic [255:0] r = '0;
        for (int k = 0; k < 4; k++) begin
            int e = c * 4 + k;
            if (e < 10) r[k*16 +: 16] = 16'(q ? 200 + e : 100 + e);
        end
        return r;
    endfunction

    task automatic a_write(input bit sel, input int s, input int e, input logic [15:0] d,
                           input bit ten, input logic [3:0] t);
        a_wr_en = 1'b1; a_wr_sel = sel; a_wr_sample = 3'(s); a_wr_elem = 4'(e);
        a_wr_data = d; a_wr_type_en = ten; a_wr_type = t;
        tick;
        a_wr_en = 1'b0; a_wr_type_en = 1'b0;
        if (sel) m_query[e] = d;
        else begin
            m_train[s][e] = d;
            if (ten) m_label[s] = t;
        end
    endtask

    task automatic b_write(input bit sel, input int e, input logic [15:0] d, input bit ten);
        b_wr_en = 1'b1; b_wr_sel = sel; b_wr_sample = 3'd0; b_wr_elem = 4'(e);
        b_wr_data = d; b_wr_type_en = ten; b_wr_type = 4'd7;
        tick;
        b_wr_en = 1'b0; b_wr_type_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 256'(a_ready), 256'(0));
        chk({tag, "_busy"},  256'(a_busy),  256'(0));
        chk({tag, "_pdone"}, 256'(a_pdone), 256'(0));
        chk({tag, "_perr"},  256'(a_perr),  256'(0));
        chk({tag, "_sidx"},  256'(a_sidx),  256'(0));
        chk({tag, "_td"},    a_td,          256'(0));
        chk({tag, "_qd"},    a_qd,          256'(0));
        chk({tag, "_type"},  256'(a_type),  256'(0));
    endtask

    // One full pass on instance A with exact cycle timing; optionally aborts by reset in a chosen WAIT.
    task automatic walk(input int cnt, input bit both, input int abort_s, input int abort_c);
        aborted = 1'b0;
        a_count = 4'(cnt); a_start = 1'b1;
        tick;
        a_start = 1'b0;
        if (cnt == 0) begin
            chk("zero_pdone", 256'(a_pdone), 256'(1));
            chk("zero_ready", 256'(a_ready), 256'(0));
            tick;
            chk("zero_pdone_off", 256'(a_pdone), 256'(0));
            chk("zero_busy_off",  256'(a_busy),  256'(0));
            return;
        end
        chk("start_load_ready", 256'(a_ready), 256'(0));
        chk("start_busy",       256'(a_busy),  256'(1));
        tick;
        for (int s = 0; s < cnt; s++) begin
            for (int c = 0; c < 4; c++) begin
                chk("ready",  256'(a_ready), 256'(1));
                chk("train",  a_td, exp_chunk(1'b0, s, c));
                chk("query",  a_qd, exp_chunk(1'b1, s, c));
                chk("label",  256'(a_type), 256'(m_label[s]));
                chk("sidx",   256'(a_sidx), 256'(s));
                chk("perr",   256'(a_perr), 256'(perr_exp));
                tick;
                if (s == abort_s && c == abort_c) begin
                    rst = 1'b1;
                    tick;
                    rst = 1'b0;
                    check_reset_outputs("midpass_rst");
                    perr_exp = 1'b0;
                    aborted  = 1'b1;
                    return;
                end
                repeat ($urandom_range(0, 2)) begin
                    a_wr_en = 1'b1; a_wr_sel = 1'($urandom); a_wr_sample = 3'($urandom);
                    a_wr_elem = 4'($urandom); a_wr_data = 16'($urandom);
                    tick;
                    chk("hold_ready", 256'(a_ready), 256'(0));
                    chk("hold_train", a_td, exp_chunk(1'b0, s, c));
                end
                a_wr_en = 1'b0;
                if (c < 3) begin
                    a_dr = 1'b1;
                    tick;
                    a_dr = 1'b0;
                    chk("req_load_ready", 256'(a_ready), 256'(0));
                    tick;
                end else begin
                    a_done = 1'b1; a_dr = both;
                    tick;
                    a_done = 1'b0; a_dr = 1'b0;
`ifdef FEEDER_PROTOCOL_CHECK_EN
                    if (both) perr_exp = 1'b1;
`endif
                    if (s == cnt - 1) begin
                        chk("pass_done", 256'(a_pdone), 256'(1));
                        chk("fin_ready", 256'(a_ready), 256'(0));
                        tick;
                        chk("pass_done_off", 256'(a_pdone), 256'(0));
                        chk("idle_busy",     256'(a_busy),  256'(0));
                    end else begin
                        chk("done_load_ready", 256'(a_ready), 256'(0));
                        chk("done_no_pdone",   256'(a_pdone), 256'(0));
                        tick;
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; perr_exp = 1'b0;
        a_wr_en = 0; a_wr_sel = 0; a_wr_sample = 0; a_wr_elem = 0; a_wr_data = 0;
        a_wr_type_en = 0; a_wr_type = 0; a_start = 0; a_count = 0; a_dr = 0; a_done = 0;
        b_wr_en = 0; b_wr_sel = 0; b_wr_sample = 0; b_wr_elem = 0; b_wr_data = 0;
        b_wr_type_en = 0; b_wr_type = 0; b_start = 0; b_count = 0; b_dr = 0; b_done = 0;
        tick; tick;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Directed: elements = sample*16+elem, query = 1, labels 3 and 5
        for (int s = 0; s < 2; s++)
            for (int e = 0; e < 16; e++)
                a_write(1'b0, s, e, 16'(s * 16 + e), e == 0, (s == 0) ? 4'd3 : 4'd5);
        for (int e = 0; e < 16; e++) a_write(1'b1, 0, e, 16'd1, 1'b0, 4'd0);
        walk(2, 1'b0, -1, -1);

        // Randomized contents and pass lengths
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < 8; s++)
                for (int e = 0; e < 16; e++)
                    a_write(1'b0, s, e, 16'($urandom), e == 0, 4'($urandom));
            for (int e = 0; e < 16; e++) a_write(1'b1, 0, e, 16'($urandom), 1'b0, 4'd0);
            walk(int'($urandom_range(1, 8)), 1'b0, -1, -1);
        end

        walk(0, 1'b0, -1, -1);

        // done with data_request on the same cycle: done wins
        walk(3, 1'b1, -1, -1);

        // Reset in WAIT of sample 1 chunk 2, then a clean pass from sample 0 chunk 0
        walk(3, 1'b0, 1, 2);
        chk("aborted", 256'(aborted), 256'(1));
        walk(2, 1'b0, -1, -1);

        // data_request while idle
        a_dr = 1'b1;
        tick;
        a_dr = 1'b0;
`ifdef FEEDER_PROTOCOL_CHECK_EN
        perr_exp = 1'b1;
`endif
        chk("idle_req_busy",  256'(a_busy),  256'(0));
        chk("idle_req_ready", 256'(a_ready), 256'(0));
        chk("idle_req_perr",  256'(a_perr),  256'(perr_exp));
        tick; tick;
        chk("perr_sticky",    256'(a_perr),  256'(perr_exp));

        // Instance B: partial final chunk
        for (int e = 0; e < 10; e++) begin
            b_write(1'b0, e, 16'(100 + e), e == 0);
            b_write(1'b1, e, 16'(200 + e), 1'b0);
        end
        b_write(1'b0, 12, 16'hDEAD, 1'b0);
        b_count = 4'd1; b_start = 1'b1;
        tick;
        b_start = 1'b0;
        chk("b_load_ready", 256'(b_ready), 256'(0));
        tick;
        for (int c = 0; c < 3; c++) begin
            chk("b_ready", 256'(b_ready), 256'(1));
            chk("b_train", 256'(b_td), b_chunk(1'b0, c));
            chk("b_query", 256'(b_qd), b_chunk(1'b1, c));
            chk("b_label", 256'(b_type), 256'(7));
            tick;
            if (c < 2) begin
                b_dr = 1'b1;
                tick;
                b_dr = 1'b0;
                tick;
            end else begin
                b_done = 1'b1;
                tick;
                b_done = 1'b0;
                chk("b_pass_done", 256'(b_pdone), 256'(1));
                tick;
                chk("b_idle_busy", 256'(b_busy), 256'(0));
                chk("b_perr",      256'(b_perr), 256'(0));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/training_data_feeder.md
# training_data_feeder

Supplies training samples and the query vector, chunk by chunk, to the distance calculator. It is the responder side of the calculator's `ready` / `data_request` / `done` handshake. It stores up to NUM_SAMPLES labelled training vectors plus one query vector in internal register memory. On `start` it walks every stored sample, presenting each in MAX_ELEMENTS-element chunks, and pulses `pass_done` after the last sample's distance is reported.

## Interface
- M, 4: rows per vector
- N, 4: columns per vector; vector length L = M*N elements
- W, 16: element width in bits
- MAX_ELEMENTS, 4: elements per chunk; chunks per sample C = ceil(L/MAX_ELEMENTS)
- TYPE_W, 4: class label width
- NUM_SAMPLES, 8: training sample capacity; IDX_W = max(1, $clog2(NUM_SAMPLES))

Ports:
- clk, in, 1: clock
- rst, in, 1: synchronous, active-high reset
- wr_en, in, 1: write one element or label
- wr_sel, in, 1: 0 = training memory, 1 = query vector
- wr_sample, in, IDX_W: target sample (training writes)
- wr_elem, in, $clog2(L): target element index
- wr_data, in, W: element value
- wr_type_en, in, 1: with wr_en and wr_sel=0, also writes wr_type to the sample label
- wr_type, in, TYPE_W: class label
- start, in, 1: begin a pass
- sample_count, in, IDX_W+1: samples in pass, latched on start
- data_request, in, 1: consumer wants next chunk
- done, in, 1: consumer finished current sample
- training_data, out, W*M*N: chunk element k at bits [(k+1)*W-1 -: W] for k < MAX_ELEMENTS; upper bits 0
- training_data_type, out, TYPE_W: label of current sample
- input_data, out, W*M*N: matching query chunk, same packing
- ready, out, 1: one-cycle pulse, chunk valid
- busy, out, 1: pass in progress
- sample_index, out, IDX_W: sample currently presented
- pass_done, out, 1: one-cycle pulse at end of pass
- protocol_error, out, 1: sticky handshake violation flag

## Operation
- States: IDLE, LOAD, PRESENT, WAIT, FINISH.
- **IDLE**
  - Writes are accepted only here.
  - On `start`:
    - latch `sample_count`, clear sample/chunk counters.
    - If count = 0, go to FINISH; otherwise go to LOAD.
  - `start` is ignored when not in IDLE.
- **LOAD**
  - Register chunk `chunk_idx` of sample `sample_index` and of the query into the output buses, plus the sample label.
  - Elements at positions ≥ L in the final partial chunk are driven 0.
  - Next state is PRESENT.
- **PRESENT**: `ready` = 1 for exactly this cycle; go to WAIT.
- **WAIT**: outputs are held stable. Events are checked in this order:
  1. `done`:
     - If sample_index+1 < count, increment sample_index, set chunk_idx = 0, go to LOAD.
     - Otherwise go to FINISH.
  2. `data_request` with chunk_idx+1 < C: increment chunk_idx, go to LOAD.
  3. `data_request` on the final chunk: ignored and flagged, stay in WAIT.
- **FINISH**: `pass_done` = 1 for one cycle, go to IDLE.
- If `done` and `data_request` are both asserted in the same cycle, `done` wins.
- `data_request` or `done` outside WAIT is ignored.
- `busy` = 1 in every state except IDLE.
- Out-of-range write indices are ignored.

## Timing
- Reset (synchronous):
  - state = IDLE.
  - `ready`, `busy`, `pass_done`, `protocol_error`, `sample_index` = 0.
  - `training_data`, `input_data`, `training_data_type` = 0.
  - Storage memory is not cleared.
- Reset mid-pass aborts the pass immediately. No `pass_done` is issued.
- `start` sampled at cycle t: `ready` at t+2.
- `data_request` sampled at cycle r: new chunk on the buses and `ready` at r+2.
- `done` sampled at cycle d:
  - Next sample's chunk 0 and `ready` at d+2.
  - If it was the last sample, `pass_done` at d+1.
- Output buses change only on the cycle leaving LOAD. They stay constant from the `ready` pulse until the next request or done.
- A write in cycle t is visible to a LOAD starting at t+1 or later.

## Configuration
- `FEEDER_PROTOCOL_CHECK_EN`
  - **Defined:** `protocol_error` is set, and stays set until reset, on any of:
    - `data_request` or `done` while not in WAIT
    - `data_request` on the final chunk
    - `done` and `data_request` in the same cycle
    - `done` before the final chunk was presented
  - **Undefined:** `protocol_error` is tied to 0. The checking logic is not compiled, and the ignore/priority behaviour above is unchanged.

## Test plan
- Defaults, 2 samples, elements = sample*16+elem, query elem = 1, labels 3 and 5, start → 4 `ready` pulses per sample, chunk k of sample 1 = {16+4k+3, …, 16+4k}, `training_data_type` = 5 during sample 1, then `pass_done` once.
- L=10, MAX_ELEMENTS=4 → C=3; third chunk holds elements 8 and 9 in slots 0–1, slots 2–3 = 0; `done` after the third chunk.
- `sample_count` = 0, start → `pass_done` at t+1, no `ready`.
- Reset asserted in WAIT of sample 1 chunk 2 → next cycle all outputs 0 and state IDLE; a new start gives `ready` at t+2 for sample 0 chunk 0.
- With the macro defined, `data_request` asserted in IDLE → `protocol_error` = 1 and stays set, state unchanged. Without the macro → `protocol_error` stays 0.
- `done` and `data_request` asserted together in WAIT → sample advances; chunk_idx = 0 at the next `ready`.
